seq_add_multiplier: RTL and testbench
=====================================

// Module: seq_add_multiplier
//
// PURPOSE
// - Sequential unsigned multiplier by repeated addition: product P accumulates operand A, B times.
// - Operands arrive one after the other on a shared data_in bus (A first, then B).
// - A datapath (A/B/P registers, adder, decrementer, zero detect) is driven by an FSM controller.
// - Intended as a small arithmetic unit where area matters more than speed.
//
// PARAMETERS
// - WIDTH  16  width of data_in, the A/B/P registers and y.
//
// PORTS
// - clk      in   1      single clock; all state updates on the rising edge.
// - rst_n    in   1      synchronous, active-low reset.
// - start    in   1      level request to begin a multiply; sampled in IDLE.
// - data_in  in   WIDTH  operand bus: A during LOAD_A, B during LOAD_B.
// - done     out  1      high while the FSM is in DONE; y is final while done=1.
// - y        out  WIDTH  product register P, driven directly (visible while accumulating).
//
// BEHAVIOUR
// - Reset (rst_n=0 at a rising edge): state=IDLE, A=B=P=0, done=0, y=0.
// - Reset mid-operation aborts immediately; no partial result is retained.
// - States and transitions:
//   - IDLE: start=1 -> LOAD_A; otherwise stay.
//   - LOAD_A: ldA=1; A<=data_in; -> LOAD_B.
//   - LOAD_B: ldB=1, clrP=1; B<=data_in, P<=0; -> MULT.
//   - MULT: B!=0 -> P<=P+A, B<=B-1, stay; B==0 -> no update, -> DONE.
//   - DONE: done=1; start=0 -> IDLE; start=1 -> stay.
//     (A held start cannot retrigger; a new multiply requires start to fall, then rise again.)
// - data_in must be valid during the LOAD_A and LOAD_B cycles; it is ignored in all other states.
// - start is ignored outside IDLE and DONE.
// - Timing: with start sampled at edge e0, A is captured at e0+1 and B at e0+2.
//   - B additions occur at edges e0+3 .. e0+B+2.
//   - done rises after edge e0+B+3.
//   - Total latency is B+3 cycles from the start-sampling edge.
// - eqz is combinational (B==0) and is evaluated on the current B register.
// - B=0 gives product 0 and a latency of 3 cycles.
// - Arithmetic is unsigned, modulo 2^WIDTH: P+A wraps silently with no overflow flag.
// - Control signals (ldA, ldB, ldP, clrP, decB) are Moore outputs decoded from the state; in MULT, ldP=decB=~eqz.
// - Simultaneous clrP and ldP never occur; if they did, clrP would take priority.
//
// STRUCTURE
// - Package seq_mul_pkg:
//   - state enum {IDLE, LOAD_A, LOAD_B, MULT, DONE} (3-bit encoding);
//   - default WIDTH constant.
// - Sub-module mul_ctrl: FSM; inputs clk, rst_n, start, eqz; outputs ldA, ldB, ldP, clrP, decB, done.
// - Datapath inline in the top: A reg, B down-counter, P reg, WIDTH adder, zero comparator.
//
// TESTING
// - Nominal: rst_n=0 for 2 cycles, then start=1; data_in=20 during LOAD_A and 8 during LOAD_B.
//   -> y=160, done=1 exactly 11 cycles after the start-sampling edge.
// - B=0: A=5, B=0 -> done after 3 cycles, y=0, no additions.
// - A=0: A=0, B=4 -> y stays 0, done after 7 cycles.
// - Wrap: A=300, B=300 -> y=90000 mod 65536 = 24464, done asserted, no error.
// - Reset mid-op: A=20, B=8, rst_n=0 after 4 MULT cycles.
//   -> next cycle state=IDLE, y=0, done=0; a rerun gives 160.
// - Handshake: hold start=1 through DONE -> done stays 1, no restart.
//   - Drop start -> IDLE next cycle.
//   - Raise start with A=7, B=3 -> y=21, done after 6 cycles.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential add-multiplier:
// the controller state encoding and the default operand width.
package seq_mul_pkg;

   // Default width of the operand bus, the A/B/P registers and the result.
   localparam int DEFAULT_WIDTH = 16;

   // Controller states, 3-bit encoding.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      MULT   = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage : seq_mul_pkg

// File: rtl/seq_add_multiplier_if.sv
// Operand/result bundle of the sequential add-multiplier.
// The master side issues start and presents operands on data_in.
// The slave side (the multiplier) returns done and the product y.
interface seq_add_multiplier_if
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] data_in;
   logic             done;
   logic [WIDTH-1:0] y;

   modport master (
      output start,
      output data_in,
      input  done,
      input  y
   );

   modport slave (
      input  start,
      input  data_in,
      output done,
      output y
   );

endinterface : seq_add_multiplier_if

// File: rtl/mul_ctrl.sv
// FSM controller for the sequential add-multiplier.
// It sequences operand loading and the repeated-add loop. All control
// outputs are Moore decodes of the current state. The only datapath
// feedback is eqz, which is high when the B down-counter has reached zero.
module mul_ctrl
   import seq_mul_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic eqz,
   output logic ldA,
   output logic ldB,
   output logic ldP,
   output logic clrP,
   output logic decB,
   output logic done
);

   state_t state;
   state_t state_nxt;

   // State register; synchronous active-low reset aborts any operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control decode.
   always_comb begin
      state_nxt = state;
      ldA       = 1'b0;
      ldB       = 1'b0;
      ldP       = 1'b0;
      clrP      = 1'b0;
      decB      = 1'b0;
      done      = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD_A;
            end
         end

         LOAD_A: begin
            ldA       = 1'b1;
            state_nxt = LOAD_B;
         end

         // Clearing P here lets the loop start accumulating on the very
         // next edge, without an extra initialisation cycle.
         LOAD_B: begin
            ldB       = 1'b1;
            clrP      = 1'b1;
            state_nxt = MULT;
         end

         // One addition per cycle while B is non-zero. When B hits zero
         // nothing is updated and the product is final.
         MULT: begin
            ldP  = ~eqz;
            decB = ~eqz;
            if (eqz) begin
               state_nxt = DONE;
            end
         end

         // done is held until start falls, so a start level left high
         // cannot launch a second multiply on its own.
         DONE: begin
            done = 1'b1;
            if (!start) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule : mul_ctrl

// File: rtl/seq_add_multiplier.sv
// Sequential unsigned multiplier by repeated addition.
// Operand A and then operand B arrive on the shared data_in bus. The
// product register P accumulates A once per cycle while the B
// down-counter decrements to zero. The result wraps modulo 2^WIDTH and
// no overflow flag is produced. P drives y directly, so partial sums are
// visible while the multiply is in progress.
module seq_add_multiplier
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_add_multiplier_if.slave  bus
);

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] p_reg;
   logic             eqz;
   logic             ld_a;
   logic             ld_b;
   logic             ld_p;
   logic             clr_p;
   logic             dec_b;
   logic             done_w;

   // Unsigned modulo-2^WIDTH add. The carry out is discarded on purpose.
   function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
      return x + z;
   endfunction

   // Zero detect on the current B count, used as the loop exit.
   assign eqz = (b_reg == '0);

   mul_ctrl u_ctrl (
      .clk   (clk),
      .rst_n (rst_n),
      .start (bus.start),
      .eqz   (eqz),
      .ldA   (ld_a),
      .ldB   (ld_b),
      .ldP   (ld_p),
      .clrP  (clr_p),
      .decB  (dec_b),
      .done  (done_w)
   );

   // Operand A register: captured once per multiply.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg <= '0;
      end else if (ld_a) begin
         a_reg <= bus.data_in;
      end
   end

   // B down-counter: loaded with the multiplier, then counted down once per addition.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         b_reg <= '0;
      end else if (ld_b) begin
         b_reg <= bus.data_in;
      end else if (dec_b) begin
         b_reg <= b_reg - 1'b1;
      end
   end

   // Product accumulator; a clear takes priority over an accumulate.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_reg <= '0;
      end else if (clr_p) begin
         p_reg <= '0;
      end else if (ld_p) begin
         p_reg <= add_mod(p_reg, a_reg);
      end
   end

   assign bus.y    = p_reg;
   assign bus.done = done_w;

endmodule : seq_add_multiplier

// File: tb/tb_seq_add_multiplier.sv
// Directed bench for seq_add_multiplier: each operation pushes its
// expected product and latency onto a scoreboard queue, which is popped
// and compared when done rises.
module tb_seq_add_multiplier;
   import seq_mul_pkg::*;

   localparam int W     = 16;
   localparam int BOUND = 1000;

   typedef struct {
      logic [W-1:0] prod;
      int           lat;
   } exp_t;

   logic clk;
   logic rst_n;
   int   test_cnt;
   int   fail_cnt;
   exp_t sb[$];

   seq_add_multiplier_if #(.WIDTH(W)) bus ();

   seq_add_multiplier #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      test_cnt++;
      assert (obs === exp_v) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Runs one multiply. The start-sampling edge is e0, A is presented
   // for edge e0+1 and B for edge e0+2. Edges are counted from e0 until
   // done is observed. With hold=0, start is released and the return to
   // IDLE is checked as well.
   task automatic do_op(input string tag, input int a, input int b, input bit hold);
      exp_t e;
      exp_t got;
      int   cycles;
      e.prod = W'((a * b) % 65536);
      e.lat  = b + 3;
      sb.push_back(e);

      @(negedge clk);
      bus.start   = 1'b1;
      bus.data_in = 16'hDEAD;
      @(posedge clk);                       // e0
      @(negedge clk);
      bus.data_in = W'(a);
      bus.start   = hold;
      @(posedge clk);                       // e0+1
      @(negedge clk);
      bus.data_in = W'(b);
      @(posedge clk);                       // e0+2
      @(negedge clk);
      bus.data_in = 16'hBEEF;
      cycles = 2;
      while (cycles < BOUND) begin
         @(posedge clk);
         cycles++;
         #1;
         if (bus.done === 1'b1) break;
      end
      got = sb.pop_front();
      check({tag, "_latency"}, 32'(cycles), 32'(got.lat));
      check({tag, "_y"},       32'(bus.y),  32'(got.prod));
      check({tag, "_done"},    32'(bus.done), 32'd1);
      if (!hold) begin
         @(posedge clk);
         #1;
         check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
      end
   endtask

   initial begin
      test_cnt    = 0;
      fail_cnt    = 0;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.data_in = '0;

      // Reset for two cycles.
      repeat (2) @(posedge clk);
      #1;
      check("reset_y",    32'(bus.y),    32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Nominal, zero multiplier, zero multiplicand, wraparound.
      do_op("nominal", 20, 8, 1'b0);
      do_op("b_zero", 5, 0, 1'b0);
      do_op("a_zero", 0, 4, 1'b0);
      do_op("wrap", 300, 300, 1'b0);

      // Reset in the middle of the accumulation loop.
      @(negedge clk);
      bus.start   = 1'b1;
      bus.data_in = 16'h1234;
      @(posedge clk);                       // e0
      @(negedge clk);
      bus.start   = 1'b0;
      bus.data_in = 16'd20;
      @(posedge clk);                       // A
      @(negedge clk);
      bus.data_in = 16'd8;
      @(posedge clk);                       // B
      repeat (4) @(posedge clk);            // four additions
      #1;
      check("midop_partial_y",    32'(bus.y),    32'd80);
      check("midop_partial_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midop_reset_y",    32'(bus.y),    32'd0);
      check("midop_reset_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("rerun", 20, 8, 1'b0);

      // Handshake: start held high through DONE must not retrigger.
      do_op("hold", 9, 2, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("hold_done_stays", 32'(bus.done), 32'd1);
      check("hold_y_stable",   32'(bus.y),    32'd18);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check("drop_start_idle", 32'(bus.done), 32'd0);
      do_op("restart", 7, 3, 1'b0);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule : tb_seq_add_multiplier
